// File: rtl/phepnhan_arb.sv
// Round-robin arbiter sharing one single-precision multiplier (phepnhan) between two
// valid/ready requesters; operands are registered, held, then the product is captured.

module phepnhan (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p,
    output logic        underflow,
    output logic        overflow
);

    logic               sign;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic [23:0]        ma;
    logic [23:0]        mb;
    logic [47:0]        m;
    logic [5:0]         lead;
    logic [5:0]         lz;
    logic signed [10:0] e_raw;
    logic signed [10:0] e_n;
    logic [22:0]        frac;
    logic [33:0]        res;

    // {underflow, overflow, product}; out-of-range exponents saturate to inf / signed zero
    function automatic logic [33:0] pack_result(input logic s, input logic signed [10:0] e,
                                                input logic [22:0] f);
        if (e > 11'sd254)
            return {2'b01, s, 8'hFF, 23'd0};
        else if (e < 11'sd1)
            return {2'b10, s, 31'd0};
        else
            return {2'b00, s, e[7:0], f};
    endfunction

    always_comb begin
        sign  = a[31] ^ b[31];
        ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma    = {a[30:23] != 8'd0, a[22:0]};
        mb    = {b[30:23] != 8'd0, b[22:0]};
        m     = {24'd0, ma} * {24'd0, mb};
        lead  = 6'd0;
        for (int i = 0; i < 47; i++) begin
            if (m[i]) lead = 6'(i);
        end
        lz    = 6'd46 - lead;
        e_raw = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
        // Subnormal inputs leave the leading one below bit 46; shift it back up (truncating)
        if (m[47]) begin
            e_n  = e_raw + 11'sd1;
            frac = 23'(m >> 24);
        end else begin
            e_n  = e_raw - $signed({5'b00000, lz});
            frac = 23'((m << lz) >> 23);
        end
        res = pack_result(sign, e_n, frac);
        if ((a[30:0] == 31'd0) || (b[30:0] == 31'd0))
            res = {2'b00, sign, 31'd0};
        underflow = res[33];
        overflow  = res[32];
        p         = res[31:0];
    end

endmodule

module phepnhan_arb #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [31:0]      resp_data,
    output logic             resp_underflow,
    output logic             resp_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    generate
        if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
            $error("phepnhan_arb: MUL_LAT must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Counter starts at MUL_LAT so operands sit on the multiplier for MUL_LAT+1 cycles
    localparam logic [3:0] LAT_INIT = 4'(MUL_LAT);

    state_t      state;
    logic        prio;
    logic        owner;
    logic [3:0]  cnt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        grant;
    logic        accept;
    logic        resp_hs;
    logic [31:0] mul_p;
    logic        mul_uf;
    logic        mul_of;

    phepnhan u_mul (
        .a         (opa),
        .b         (opb),
        .p         (mul_p),
        .underflow (mul_uf),
        .overflow  (mul_of)
    );

    // Ready is gated by rst so every output reads zero while reset is held
    always_comb begin
        grant      = prio ? req1_valid : ~req0_valid;
        accept     = (state == IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        resp_hs    = owner ? (resp1_valid && resp1_ready) : (resp0_valid && resp0_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            prio           <= 1'b0;
            owner          <= 1'b0;
            cnt            <= 4'd0;
            opa            <= 32'd0;
            opb            <= 32'd0;
            resp0_valid    <= 1'b0;
            resp1_valid    <= 1'b0;
            resp_data      <= 32'd0;
            resp_underflow <= 1'b0;
            resp_overflow  <= 1'b0;
            busy           <= 1'b0;
            op_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa   <= grant ? req1_a : req0_a;
                        opb   <= grant ? req1_b : req0_b;
                        owner <= grant;
                        cnt   <= LAT_INIT;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        resp_data      <= mul_p;
                        resp_underflow <= mul_uf;
                        resp_overflow  <= mul_of;
                        resp0_valid    <= ~owner;
                        resp1_valid    <= owner;
                        state          <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (resp_hs) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        prio        <= ~owner;
                        op_count    <= op_count + 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phepnhan_arb.sv
// Self-checking bench for phepnhan_arb: directed scenarios plus randomized traffic
// compared with a transaction-level arbiter model and an arithmetic multiplier model.

module tb_phepnhan_arb;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_data;
    logic        resp_underflow, resp_overflow, busy;
    logic [15:0] op_count;

    logic        rst_w;
    logic        w_req_valid, w_req_ready, w_req1_valid, w_req1_ready;
    logic [31:0] w_a, w_b, w_a1, w_b1;
    logic        w_resp0_valid, w_resp0_ready, w_resp1_valid, w_resp1_ready;
    logic [31:0] w_data;
    logic        w_uf, w_of, w_busy;
    logic [2:0]  w_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_prio   = 1'b0;
    int m_count  = 0;

    always #5 clk = ~clk;

    phepnhan_arb #(.MUL_LAT(LAT), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_underflow(resp_underflow), .resp_overflow(resp_overflow),
        .busy(busy), .op_count(op_count)
    );

    phepnhan_arb #(.MUL_LAT(1), .CNT_W(3)) u_wrap (
        .clk(clk), .rst(rst_w),
        .req0_valid(w_req_valid), .req0_ready(w_req_ready), .req0_a(w_a), .req0_b(w_b),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_a(w_a1), .req1_b(w_b1),
        .resp0_valid(w_resp0_valid), .resp0_ready(w_resp0_ready),
        .resp1_valid(w_resp1_valid), .resp1_ready(w_resp1_ready),
        .resp_data(w_data), .resp_underflow(w_uf), .resp_overflow(w_of),
        .busy(w_busy), .op_count(w_count)
    );

    // Real-number style multiply on integers: returns {underflow, overflow, product}, truncated
    function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        bit         s = a[31] ^ b[31];
        longint     ma, mb, prod;
        int         ea, eb, e;
        logic [7:0] eb8;
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {2'b00, s, 31'd0};
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb8 = b[30:23];
        eb = (eb8 == 0) ? 1 : int'(eb8);
        ma = (a[30:23] == 0) ? longint'(a[22:0]) : (longint'(1) << 23) + longint'(a[22:0]);
        mb = (eb8 == 0) ? longint'(b[22:0]) : (longint'(1) << 23) + longint'(b[22:0]);
        prod = ma * mb;
        e = ea + eb - 127;
        while (prod >= (longint'(1) << 47)) begin prod = prod / 2; e = e + 1; end
        while (prod <  (longint'(1) << 46)) begin prod = prod * 2; e = e - 1; end
        if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b10, s, 31'd0};
        return {2'b00, s, 8'(e), 23'((prod >> 23) & 64'h7FFFFF)};
    endfunction

    function automatic logic [31:0] gen_operand();
        int         sel = int'($urandom_range(0, 9));
        logic [7:0] e;
        if (sel == 0) return {1'($urandom), 31'd0};
        if (sel <= 2)      e = 8'($urandom_range(200, 254));
        else if (sel <= 4) e = 8'($urandom_range(0, 40));
        else               e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Runs one transaction from an IDLE negedge and reports what the DUT did
    task automatic drive_op(input bit v0, input bit v1,
                            input logic [31:0] a0, input logic [31:0] b0,
                            input logic [31:0] a1, input logic [31:0] b1,
                            input int hold_n, input bit poke,
                            output bit rdy0, output bit rdy1, output int lat,
                            output bit busy_ok, output bit stable_ok,
                            output logic [31:0] data, output bit uf, output bit of,
                            output bit got0, output bit got1, output bit post_ok);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        rdy0 = req0_ready; rdy1 = req1_ready;
        @(posedge clk);
        @(negedge clk);
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        lat = 0; busy_ok = 1'b1;
        while (!(resp0_valid || resp1_valid) && lat < 40) begin
            req0_valid = poke && (lat == 0);
            req1_valid = poke && (lat == 0);
            #1;
            if (!busy || req0_ready || req1_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        got0 = resp0_valid; got1 = resp1_valid;
        data = resp_data; uf = resp_underflow; of = resp_overflow;
        stable_ok = 1'b1;
        for (int k = 0; k < hold_n; k++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            if (got1) resp0_ready = 1'b1; else resp1_ready = 1'b1;
            #1;
            if (resp0_valid !== got0 || resp1_valid !== got1 || resp_data !== data ||
                resp_underflow !== uf || resp_overflow !== of ||
                req0_ready || req1_ready || !busy) stable_ok = 1'b0;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = got0; resp1_ready = got1;
        @(negedge clk);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        #1;
        post_ok = !resp0_valid && !resp1_valid && !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_w = 1'b1;
        @(negedge clk);
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_gated: got %b expected 0", req1_ready);
        end
        req1_valid = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_underflow, resp_overflow} !== 7'd0
            || resp_data !== 32'd0 || op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl=%b data=%h cnt=%h expected all zero",
                     {req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_underflow, resp_overflow},
                     resp_data, op_count);
        end
        @(negedge clk);
        rst = 1'b0; rst_w = 1'b0;
        m_prio = 1'b0; m_count = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || op_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_release: busy=%b cnt=%h expected 0/0", busy, op_count);
        end
    endtask

    task automatic test_basic();
        bit r0, r1, bok, sok, uf, of, g0, g1, pok;
        int lat;
        logic [31:0] d;
        drive_op(1, 0, 32'h3FC00000, 32'h40000000, 0, 0, 0, 0, r0, r1, lat, bok, sok, d, uf, of, g0, g1, pok);
        m_prio = 1'b1; m_count++;
        n_checks++;
        if ({r0, r1} !== 2'b10) begin n_fail++; $display("FAIL basic_ready: got %b expected 10", {r0, r1}); end
        n_checks++;
        if (lat !== LAT + 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT + 1); end
        n_checks++;
        if ({g0, g1} !== 2'b10) begin n_fail++; $display("FAIL basic_resp_valid: got %b expected 10", {g0, g1}); end
        n_checks++;
        if (d !== 32'h40400000 || uf !== 1'b0 || of !== 1'b0) begin
            n_fail++; $display("FAIL basic_data: got %h uf=%b of=%b expected 40400000 0 0", d, uf, of);
        end
        n_checks++;
        if (op_count !== 16'd1 || !pok || !bok) begin
            n_fail++; $display("FAIL basic_done: cnt=%0d post=%b busy_ok=%b expected 1 1 1", op_count, pok, bok);
        end
    endtask

    task automatic test_fairness();
        bit r0, r1, bok, sok, uf, of, g0, g1, pok, g;
        int lat;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            drive_op(1, 1, 32'h3FC00000, 32'h40000000, 32'h3FA00000, 32'h3F000000, 1, 0,
                     r0, r1, lat, bok, sok, d, uf, of, g0, g1, pok);
            g = m_prio;
            m_prio = ~g; m_count++;
            n_checks++;
            if ({r0, r1} !== {~g, g} || {g0, g1} !== {~g, g}) begin
                n_fail++; $display("FAIL fair_grant%0d: ready=%b resp=%b expected owner %0d", i, {r0, r1}, {g0, g1}, g);
            end
            n_checks++;
            if (d !== (g ? 32'h3F200000 : 32'h40400000)) begin
                n_fail++; $display("FAIL fair_data%0d: got %h for owner %0d", i, d, g);
            end
        end
    endtask

    task automatic test_hold();
        bit r0, r1, bok, sok, uf, of, g0, g1, pok;
        int lat;
        logic [31:0] d;
        m_prio = 1'b0;
        drive_op(1, 0, 32'h40A00000, 32'hC0400000, 0, 0, 5, 0, r0, r1, lat, bok, sok, d, uf, of, g0, g1, pok);
        m_count++;
        n_checks++;
        if (!sok || !bok) begin n_fail++; $display("FAIL hold_stable: stable=%b busy=%b expected 1 1", sok, bok); end
        n_checks++;
        if (d !== 32'hC1700000 || {g0, g1} !== 2'b10) begin
            n_fail++; $display("FAIL hold_data: got %h resp=%b expected c1700000 10", d, {g0, g1});
        end
        n_checks++;
        if (op_count !== 16'(m_count) || !pok) begin
            n_fail++; $display("FAIL hold_count: got %0d post=%b expected %0d 1", op_count, pok, m_count);
        end
        m_prio = 1'b1;
    endtask

    task automatic test_flags();
        bit r0, r1, bok, sok, uf, of, g0, g1, pok;
        int lat;
        logic [31:0] d;
        drive_op(0, 1, 0, 0, 32'h7F500000, 32'hBFD00000, 0, 0, r0, r1, lat, bok, sok, d, uf, of, g0, g1, pok);
        m_prio = 1'b0; m_count++;
        n_checks++;
        if (of !== 1'b1 || uf !== 1'b0 || d !== 32'hFF800000 || {g0, g1} !== 2'b01) begin
            n_fail++; $display("FAIL flags_overflow: of=%b uf=%b data=%h resp=%b expected 1 0 ff800000 01", of, uf, d, {g0, g1});
        end
        drive_op(0, 1, 0, 0, 32'h00500000, 32'hBED00000, 0, 0, r0, r1, lat, bok, sok, d, uf, of, g0, g1, pok);
        m_prio = 1'b0; m_count++;
        n_checks++;
        if (uf !== 1'b1 || of !== 1'b0 || d !== 32'h80000000) begin
            n_fail++; $display("FAIL flags_underflow: uf=%b of=%b data=%h expected 1 0 80000000", uf, of, d);
        end
    endtask

    task automatic test_drop();
        bit r0, r1, bok, sok, uf, of, g0, g1, pok, idle_ok;
        int lat;
        logic [31:0] d;
        drive_op(1, 0, 32'h3F800000, 32'h3F800000, 0, 0, 0, 1, r0, r1, lat, bok, sok, d, uf, of, g0, g1, pok);
        m_prio = 1'b1; m_count++;
        idle_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy || resp0_valid || resp1_valid) idle_ok = 1'b0;
        end
        n_checks++;
        if (!bok || !idle_ok || op_count !== 16'(m_count) || d !== 32'h3F800000) begin
            n_fail++; $display("FAIL drop_no_state: busy_ok=%b idle=%b cnt=%0d data=%h expected 1 1 %0d 3f800000",
                               bok, idle_ok, op_count, d, m_count);
        end
    endtask

    task automatic test_random();
        bit r0, r1, bok, sok, uf, of, g0, g1, pok, v0, v1, g;
        int lat, vp;
        logic [31:0] d, a0, b0, a1, b1;
        logic [33:0] exp_r;
        for (int i = 0; i < 30; i++) begin
            vp = int'($urandom_range(1, 3));
            v0 = vp[0]; v1 = vp[1];
            a0 = gen_operand(); b0 = gen_operand(); a1 = gen_operand(); b1 = gen_operand();
            g = m_prio ? v1 : ~v0;
            exp_r = g ? ref_mul(a1, b1) : ref_mul(a0, b0);
            drive_op(v0, v1, a0, b0, a1, b1, int'($urandom_range(0, 3)), 1'($urandom),
                     r0, r1, lat, bok, sok, d, uf, of, g0, g1, pok);
            m_prio = ~g; m_count++;
            n_checks++;
            if ({r0, r1, g0, g1} !== {~g, g, ~g, g} || lat !== LAT + 1) begin
                n_fail++; $display("FAIL rand_grant%0d: ready=%b resp=%b lat=%0d expected owner %0d lat %0d",
                                   i, {r0, r1}, {g0, g1}, lat, g, LAT + 1);
            end
            n_checks++;
            if ({uf, of, d} !== exp_r) begin
                n_fail++; $display("FAIL rand_result%0d: got %b%b_%h expected %b_%h", i, uf, of, d, exp_r[33:32], exp_r[31:0]);
            end
            n_checks++;
            if (!bok || !sok || !pok || op_count !== 16'(m_count)) begin
                n_fail++; $display("FAIL rand_protocol%0d: busy=%b stable=%b post=%b cnt=%0d expected 1 1 1 %0d",
                                   i, bok, sok, pok, op_count, m_count);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        bit quiet, r0, r1, bok, sok, uf, of, g0, g1, pok;
        int lat;
        logic [31:0] d;
        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_underflow, resp_overflow} !== 7'd0
            || resp_data !== 32'd0 || op_count !== 16'd0) begin
            n_fail++; $display("FAIL rst_exec_outputs: ctl=%b data=%h cnt=%h expected all zero",
                               {req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_underflow, resp_overflow},
                               resp_data, op_count);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        rst = 1'b0;
        m_prio = 1'b0; m_count = 0;
        quiet = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid || busy) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin n_fail++; $display("FAIL rst_exec_no_resp: activity seen after reset, expected none"); end
        drive_op(1, 1, 32'h3FC00000, 32'h40000000, 32'h3FA00000, 32'h3F000000, 0, 0,
                 r0, r1, lat, bok, sok, d, uf, of, g0, g1, pok);
        m_prio = 1'b1; m_count++;
        n_checks++;
        if ({r0, r1, g0, g1} !== 4'b1010 || d !== 32'h40400000 || op_count !== 16'd1) begin
            n_fail++; $display("FAIL rst_exec_next: ready=%b resp=%b data=%h cnt=%0d expected 10 10 40400000 1",
                               {r0, r1}, {g0, g1}, d, op_count);
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [31:0] a, b, d;
        logic [33:0] exp_r;
        w_resp0_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a = gen_operand(); b = gen_operand();
            exp_r = ref_mul(a, b);
            w_req_valid = 1'b1; w_a = a; w_b = b;
            @(posedge clk);
            @(negedge clk);
            w_req_valid = 1'b0; w_a = $urandom;
            n = 0;
            while (!w_resp0_valid && n < 20) begin @(negedge clk); n++; end
            d = w_data;
            n_checks++;
            if ({w_uf, w_of, d} !== exp_r || n !== 2) begin
                n_fail++; $display("FAIL wrap_result%0d: got %b%b_%h lat=%0d expected %b_%h lat 2",
                                   i, w_uf, w_of, d, n, exp_r[33:32], exp_r[31:0]);
            end
            @(negedge clk);
            n_checks++;
            if (w_count !== 3'((i + 1) % 8) || w_busy) begin
                n_fail++; $display("FAIL wrap_count%0d: got %0d busy=%b expected %0d 0", i, w_count, w_busy, (i + 1) % 8);
            end
        end
        w_resp0_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 0; resp1_ready = 0;
        w_req_valid = 0; w_req1_valid = 0; w_a = 0; w_b = 0; w_a1 = 0; w_b1 = 0;
        w_resp0_ready = 0; w_resp1_ready = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_fairness();
        test_hold();
        test_flags();
        test_drop();
        test_random();
        test_reset_mid_exec();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
